// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display source selector.
//   SEG_RST_PATTERN : display word shown at reset and for an unmapped channel
//   POINT_DEFAULT   : decimal points for channels without their own mask
//   BLINK_DEFAULT   : blink mask for channels without their own mask
//   mode_e          : channel-selection mode of the scan controller
package seven_seg_pkg;
  localparam logic [31:0] SEG_RST_PATTERN = 32'hAA5555AA;
  localparam logic [3:0]  POINT_DEFAULT   = 4'hF;
  localparam logic [3:0]  BLINK_DEFAULT   = 4'h0;

  typedef enum logic {MODE_MANUAL, MODE_SCAN} mode_e;
endpackage

// File: rtl/seven_seg_scan_ctr.sv
// Channel-select controller: manual select or auto-scan over enabled channels.
//   clk, rst    : clock, async active-low reset
//   auto_en     : 1 = auto-scan, 0 = manual (cur_ch follows sel)
//   sel         : manual channel select
//   ch_en       : auto-scan enable mask, bit k enables channel k
//   dwell_len   : cycles spent on each channel while scanning (0 acts as 1)
//   cur_nxt     : channel that will be active after this edge (feeds the output mux)
//   cur_ch      : channel currently driving the outputs
//   ch_switch   : one-cycle pulse after an edge where cur_ch changed
module seven_seg_scan_ctr
  import seven_seg_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               auto_en,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_CH-1:0]    ch_en,
  input  logic [DWELL_W-1:0] dwell_len,
  output logic [SEL_W-1:0]   cur_nxt,
  output logic [SEL_W-1:0]   cur_ch,
  output logic               ch_switch
);

  mode_e              mode, mode_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt, term;
  logic [SEL_W-1:0]   fold, rot_nxt;
  logic               cur_on;

  assign term = (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
  // cur_ch may hold an out-of-range manual select; scanning restarts from 0 then.
  assign fold = ({1'b0, cur_ch} < (SEL_W+1)'(N_CH)) ? cur_ch : '0;

  // Priority rotate: first enabled channel above cur_ch, wrapping. The outer
  // loop runs from the largest offset down so the smallest offset wins. If no
  // other channel is enabled, rot_nxt stays on cur_ch.
  always_comb begin
    rot_nxt = cur_ch;
    cur_on  = 1'b0;
    for (int k = N_CH-1; k >= 1; k--)
      for (int j = 0; j < N_CH; j++)
        if (cur_ch == SEL_W'(j) && ch_en[(j+k) % N_CH])
          rot_nxt = SEL_W'((j+k) % N_CH);
    for (int j = 0; j < N_CH; j++)
      if (cur_ch == SEL_W'(j)) cur_on = ch_en[j];
  end

  always_comb begin
    mode_nxt = auto_en ? MODE_SCAN : MODE_MANUAL;
    cur_nxt  = cur_ch;
    cnt_nxt  = '0;
    if (!auto_en)
      cur_nxt = sel;
    else if (mode == MODE_MANUAL)
      cur_nxt = fold;
    else if (ch_en == '0)
      cur_nxt = '0;
    else if (!cur_on || cnt >= term)   // >= also covers dwell_len shrinking mid-dwell
      cur_nxt = rot_nxt;
    else
      cnt_nxt = (&cnt) ? cnt : cnt + DWELL_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode      <= MODE_MANUAL;
      cur_ch    <= '0;
      cnt       <= '0;
      ch_switch <= 1'b0;
    end else begin
      mode      <= mode_nxt;
      cur_ch    <= cur_nxt;
      cnt       <= cnt_nxt;
      ch_switch <= (cur_nxt != cur_ch);
    end
  end

endmodule

// File: rtl/seven_seg_src_sel.sv
// Registered source selector for the seven-segment display path.
//   clk, rst            : clock, async active-low reset
//   cpu_we, cpu_data    : write port of the channel-0 CPU display register
//   point_in, blink_in  : point / blink masks used when channel 0 is shown
//   ch_data             : packed channels 1..N_CH-1, channel k at [k*WIDTH-1 -: WIDTH]
//   sel, auto_en, ch_en, dwell_len : channel selection controls
//   disp_num, point_out, blink_out : registered display outputs
//   cur_ch, ch_switch   : active channel and change pulse
module seven_seg_src_sel
  import seven_seg_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          N_CH        = 8,
  parameter int          SEL_W       = 4,
  parameter logic [31:0] RST_PATTERN = SEG_RST_PATTERN,
  parameter int          DWELL_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_we,
  input  logic [WIDTH-1:0]           cpu_data,
  input  logic [3:0]                 point_in,
  input  logic [3:0]                 blink_in,
  input  logic [(N_CH-1)*WIDTH-1:0]  ch_data,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       auto_en,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [DWELL_W-1:0]         dwell_len,
  output logic [WIDTH-1:0]           disp_num,
  output logic [3:0]                 point_out,
  output logic [3:0]                 blink_out,
  output logic [SEL_W-1:0]           cur_ch,
  output logic                       ch_switch
);

  logic [WIDTH-1:0]           cpu_reg;
  logic [N_CH-1:0][WIDTH-1:0] ch_arr;
  logic [SEL_W-1:0]           cur_nxt;
  logic [WIDTH-1:0]           disp_nxt;
  logic [3:0]                 point_nxt, blink_nxt;

  seven_seg_scan_ctr #(
    .N_CH    (N_CH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .auto_en   (auto_en),
    .sel       (sel),
    .ch_en     (ch_en),
    .dwell_len (dwell_len),
    .cur_nxt   (cur_nxt),
    .cur_ch    (cur_ch),
    .ch_switch (ch_switch)
  );

  // Channel 0 bypasses the CPU register so a write shows after one edge.
  assign ch_arr[0] = cpu_we ? cpu_data : cpu_reg;

  for (genvar k = 1; k < N_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data[k*WIDTH-1 -: WIDTH];
  end

  always_comb begin
    disp_nxt  = WIDTH'(RST_PATTERN);
    point_nxt = POINT_DEFAULT;
    blink_nxt = BLINK_DEFAULT;
    for (int k = 0; k < N_CH; k++)
      if (cur_nxt == SEL_W'(k)) disp_nxt = ch_arr[k];
    if (cur_nxt == '0) begin
      point_nxt = point_in;
      blink_nxt = blink_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_reg   <= '0;
      disp_num  <= WIDTH'(RST_PATTERN);
      point_out <= POINT_DEFAULT;
      blink_out <= BLINK_DEFAULT;
    end else begin
      if (cpu_we) cpu_reg <= cpu_data;
      disp_num  <= disp_nxt;
      point_out <= point_nxt;
      blink_out <= blink_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_src_sel.sv
module tb_seven_seg_src_sel;
  localparam int N = 8;

  logic              clk = 0;
  logic              rst = 1;
  logic              cpu_we = 0;
  logic [31:0]       cpu_data = 0;
  logic [3:0]        point_in = 0, blink_in = 0;
  logic [7*32-1:0]   ch_data = 0;
  logic [3:0]        sel = 0;
  logic              auto_en = 0;
  logic [7:0]        ch_en = 0;
  logic [15:0]       dwell_len = 0;
  logic [31:0]       disp_num;
  logic [3:0]        point_out, blink_out, cur_ch;
  logic              ch_switch;

  seven_seg_src_sel dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .point_in(point_in), .blink_in(blink_in), .ch_data(ch_data),
    .sel(sel), .auto_en(auto_en), .ch_en(ch_en), .dwell_len(dwell_len),
    .disp_num(disp_num), .point_out(point_out), .blink_out(blink_out),
    .cur_ch(cur_ch), .ch_switch(ch_switch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic chk_on = 0;
  logic [31:0] chd [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cur = 0, m_cnt = 0, m_prev, m_nc, m_term;
  bit          m_scan = 0, m_sw = 0;
  logic [31:0] m_cpu = 0, m_disp = 32'hAA5555AA;
  logic [3:0]  m_pt = 4'hF, m_bl = 4'h0;

  function automatic int next_on(input int c);
    int n = (c + 1) % N;
    while (!ch_en[n] && n != c) n = (n + 1) % N;
    return ch_en[n] ? n : c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cur = 0; m_cnt = 0; m_scan = 0; m_sw = 0; m_cpu = 0;
      m_disp = 32'hAA5555AA; m_pt = 4'hF; m_bl = 4'h0;
    end else begin
      m_prev = m_cur;
      if (!auto_en) begin
        m_nc = int'(sel); m_cnt = 0; m_scan = 0;
      end else if (!m_scan) begin
        m_nc = (m_cur < N) ? m_cur : 0; m_cnt = 0; m_scan = 1;
      end else if (ch_en == 0) begin
        m_nc = 0; m_cnt = 0;
      end else begin
        m_term = (dwell_len == 0) ? 0 : int'(dwell_len) - 1;
        if (!ch_en[m_cur] || m_cnt >= m_term) begin
          m_nc = next_on(m_cur); m_cnt = 0;
        end else begin
          m_nc = m_cur;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (m_nc == 0) begin
        m_disp = cpu_we ? cpu_data : m_cpu; m_pt = point_in; m_bl = blink_in;
      end else begin
        m_disp = (m_nc < N) ? chd[m_nc] : 32'hAA5555AA; m_pt = 4'hF; m_bl = 4'h0;
      end
      if (cpu_we) m_cpu = cpu_data;
      m_sw = (m_nc != m_prev);
      m_cur = m_nc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("disp_num",  disp_num,        m_disp);
      check("point_out", 32'(point_out),  32'(m_pt));
      check("blink_out", 32'(blink_out),  32'(m_bl));
      check("cur_ch",    32'(cur_ch),     32'(m_cur));
      check("ch_switch", 32'(ch_switch),  32'(m_sw));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int exp_seq [10] = '{0,0,0,2,2,2,5,5,5,0};
  int exp_sw  [10] = '{0,0,0,1,0,0,1,0,0,1};
  int adv_seq [4]  = '{2,5,0,2};

  initial begin
    for (int k = 0; k < N; k++) chd[k] = 32'h11111111 * k;
    chd[3] = 32'hDEADBEEF;
    for (int k = 1; k < N; k++) ch_data[k*32-1 -: 32] = chd[k];

    #1 rst = 0;
    chk_on = 1;
    tick(2);
    check("rst_disp",  disp_num, 32'hAA5555AA);
    check("rst_point", 32'(point_out), 32'hF);
    check("rst_cur",   32'(cur_ch), 0);

    rst = 1;
    tick(1);
    check("rel_sw", 32'(ch_switch), 0);

    // CPU bypass on channel 0
    point_in = 4'b0101; cpu_we = 1; cpu_data = 32'h12345678;
    tick(1);
    check("cpu_bypass", disp_num, 32'h12345678);
    check("cpu_point",  32'(point_out), 32'h5);
    cpu_we = 0; cpu_data = 0;
    tick(2);
    check("cpu_hold", disp_num, 32'h12345678);

    // Manual select and out-of-range
    sel = 3;
    tick(1);
    check("man3_disp",  disp_num, 32'hDEADBEEF);
    check("man3_point", 32'(point_out), 32'hF);
    sel = 9;
    tick(1);
    check("man9_disp", disp_num, 32'hAA5555AA);
    check("man9_cur",  32'(cur_ch), 9);

    // Auto-scan with mask
    sel = 0;
    tick(1);
    ch_en = 8'b0010_0101; dwell_len = 3; auto_en = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("scan_cur", 32'(cur_ch), 32'(exp_seq[i]));
      check("scan_sw",  32'(ch_switch), 32'(exp_sw[i]));
    end

    // dwell_len 0 advances each edge
    dwell_len = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("dwell0_cur", 32'(cur_ch), 32'(adv_seq[i]));
    end

    // all disabled pins channel 0
    ch_en = 0;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("none_cur", 32'(cur_ch), 0);
    end

    // single enabled channel
    ch_en = 8'b0001_0000; dwell_len = 2;
    tick(1);
    check("one_cur", 32'(cur_ch), 4);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("one_hold", 32'(cur_ch), 4);
      check("one_nosw", 32'(ch_switch), 0);
    end

    // Mode switch mid-dwell on ch2
    ch_en = 8'b0010_0101; dwell_len = 5;
    for (int i = 0; i < 40 && cur_ch != 2; i++) tick(1);
    check("reach_ch2", 32'(cur_ch), 2);
    tick(1);
    auto_en = 0; sel = 6;
    tick(1);
    check("msw_cur", 32'(cur_ch), 6);
    check("msw_sw",  32'(ch_switch), 1);
    ch_en = 8'b0110_0101; auto_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("resume6", 32'(cur_ch), 6);
    end
    tick(1);
    check("wrap0", 32'(cur_ch), 0);

    // Asynchronous reset mid-run with auto-scan on
    tick(3);
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("arst_disp",  disp_num, 32'hAA5555AA);
    check("arst_point", 32'(point_out), 32'hF);
    check("arst_blink", 32'(blink_out), 0);
    check("arst_cur",   32'(cur_ch), 0);
    tick(1);
    rst = 1;
    tick(1);
    check("arel_cur", 32'(cur_ch), 0);
    check("arel_sw",  32'(ch_switch), 0);
    tick(4);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
